// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for decode-stage hazard detection.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned DISPLAY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRD*$clog2(NREGS)-1:0]   ra,
  output logic [NRD*XLEN-1:0]            rd,
  output logic [NRD-1:0]                 rbusy,
  input  logic [NWR-1:0]                 we,
  input  logic [NWR*$clog2(NREGS)-1:0]   wa,
  input  logic [NWR*XLEN-1:0]            wd,
  input  logic                           sb_set,
  input  logic [$clog2(NREGS)-1:0]       sb_idx,
  input  logic                           sb_flush
);

  localparam int unsigned IDXW = $clog2(NREGS);

  // Reject parameter values the port decoding does not support.
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be 1..4");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp: NWR must be 1..2");
  end
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of 2");
  end

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [IDXW-1:0]  wa_a [NWR];
  logic [XLEN-1:0]  wd_a [NWR];
  logic [NWR-1:0]   win;

  for (genvar k = 0; k < NWR; k++) begin : g_wslice
    assign wa_a[k] = wa[k*IDXW +: IDXW];
    assign wd_a[k] = wd[k*XLEN +: XLEN];
  end

  // A write commits only if it targets a nonzero register and no higher port hits the same one.
  always_comb begin
    win = '0;
    for (int k = 0; k < NWR; k++) begin
      win[k] = we[k] && (wa_a[k] != '0);
      for (int j = k + 1; j < NWR; j++) begin
        if (we[j] && (wa_a[j] == wa_a[k])) win[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (win[k]) begin
          rf[wa_a[k]] <= wd_a[k];
          if (DISPLAY != 0) $display("x%d = %h", wa_a[k], wd_a[k]);
        end
      end
    end
  end

  // Priority: flush over set over write-clear.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (win[k]) busy_nxt[wa_a[k]] = 1'b0;
    end
    if (sb_set && (sb_idx != '0)) busy_nxt[sb_idx] = 1'b1;
    if (sb_flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    logic [IDXW-1:0] addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = ra[i*IDXW +: IDXW];

    // Highest matching write port is applied last and therefore wins the bypass.
    always_comb begin
      data = rf[addr];
      bsy  = busy[addr];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (wa_a[k] == addr)) begin
            data = wd_a[k];
            bsy  = 1'b0;
          end
        end
      end
      if (reset || (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rbusy[i]           = bsy;
  end

endmodule
